pattern_fetch: RTL and testbench

- Blitter-side read engine that sits directly upstream of the pattern memory's blitter port.
- Accepts a rectangle command: base address, width, height and row stride.
- Issues 32-bit word reads to the pattern memory and unpacks each word into a 1-bit-per-pixel stream.
- The blitter's pixel pipeline consumes that stream through a valid/ready handshake.

---
 rtl/blit_pkg.sv | 18 +
 rtl/pattern_word_fifo.sv | 50 +++++
 rtl/pattern_fetch.sv | 194 +++++++++++++++++++
 tb/tb_pattern_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter-side pattern path.
//   pattern_cmd_t : rectangle command. Fields are held at 16 bits so the same
//                   type serves any width/height parameterisation up to 16 bits.
//   WORD_BYTES    : bytes per pattern memory word.
//   PIX_PER_WORD  : 1-bpp pixels packed in one memory word.
package blit_pkg;

    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned PIX_PER_WORD = 32;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] width;
        logic [15:0] height;
        logic [15:0] stride;
    } pattern_cmd_t;

endpackage

// File: rtl/pattern_word_fifo.sv
// Two-entry FIFO of pattern memory words.
//   clock, resetn : clock and asynchronous active-low reset (empties the FIFO)
//   push, wdata   : write a word; ignored when full unless a pop happens too
//   pop           : drop the head word; ignored when empty
//   rdata         : head word (meaningful when count != 0)
//   count         : number of stored words, 0..2
module pattern_word_fifo
    import blit_pkg::*;
(
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    push,
    input  logic [PIX_PER_WORD-1:0] wdata,
    input  logic                    pop,
    output logic [PIX_PER_WORD-1:0] rdata,
    output logic [1:0]              count
);

    logic [PIX_PER_WORD-1:0] mem_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic                    do_push;
    logic                    do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/pattern_fetch.sv
// Pattern read engine for the blitter.
// Accepts a rectangle command, reads 32-bit pattern words row by row and
// unpacks them LSB first into a 1-bpp pixel stream with row/frame markers.
//   clock, resetn             : clock, asynchronous active-low reset
//   cmd_*                     : command handshake and fields (addr/stride bits [1:0] ignored)
//   mem_request/addr/ack/rdata: read port, response exactly one cycle after request
//   mem_write/byte_enable/wdata: tied off (read-only client)
//   pix_valid/ready/data/eol/eof: pixel stream
//   busy                      : command in progress
//   done                      : one-cycle completion pulse
module pattern_fetch
    import blit_pkg::*;
#(
    parameter int unsigned MAX_W_BITS = 11,
    parameter int unsigned MAX_H_BITS = 10
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [15:0]           cmd_addr,
    input  logic [MAX_W_BITS-1:0] cmd_width,
    input  logic [MAX_H_BITS-1:0] cmd_height,
    input  logic [15:0]           cmd_stride,
    output logic                  mem_request,
    output logic [15:0]           mem_addr,
    output logic                  mem_write,
    output logic [3:0]            mem_byte_enable,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e       state_q, state_d;
    pattern_cmd_t cmd_in;

    logic [15:0] width_q, width_d, height_q, height_d, stride_q, stride_d;
    logic [15:0] wpr_q, wpr_d;
    logic [15:0] row_base_q, row_base_d, word_idx_q, word_idx_d, req_row_q, req_row_d;
    logic        req_active_q, req_active_d, outstanding_q, outstanding_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [15:0] pix_col_q, pix_col_d, pix_row_q, pix_row_d;

    logic [1:0]  fifo_count;
    logic [31:0] fifo_head;
    logic        fifo_push, fifo_pop;
    logic        run, pix_fire, last_word, last_row, degenerate;

    assign cmd_in = '{addr: cmd_addr, width: 16'(cmd_width), height: 16'(cmd_height),
                      stride: cmd_stride};

    assign mem_write       = 1'b0;
    assign mem_byte_enable = 4'hF;
    assign mem_wdata       = 32'h0;

    assign run       = (state_q == StRun);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = !cmd_ready;
    assign done      = (state_q == StFinish);

    // Buffered plus in-flight words never exceed the two FIFO slots.
    assign mem_request = run && req_active_q && ((3'(fifo_count) + 3'(outstanding_q)) < 3'd2);
    assign mem_addr    = row_base_q + 16'(word_idx_q * WORD_BYTES);
    // Acks without a matching request (e.g. across reset) are dropped.
    assign fifo_push   = mem_ack && outstanding_q;

    assign pix_valid = run && (fifo_count != 2'd0);
    assign pix_data  = fifo_head[bit_idx_q];
    assign pix_eol   = pix_valid && (pix_col_q == width_q - 16'd1);
    assign pix_eof   = pix_eol && (pix_row_q == height_q - 16'd1);
    assign pix_fire  = pix_valid && pix_ready;
    // A row's tail bits are discarded by popping its last word at end of row.
    assign fifo_pop  = pix_fire && (pix_eol || (bit_idx_q == 5'(PIX_PER_WORD - 1)));

    assign last_word  = (word_idx_q == wpr_q - 16'd1);
    assign last_row   = (req_row_q == height_q - 16'd1);
    assign degenerate = (cmd_in.width == 16'd0) || (cmd_in.height == 16'd0);

    pattern_word_fifo u_fifo (
        .clock (clock),
        .resetn(resetn),
        .push  (fifo_push),
        .wdata (mem_rdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        stride_d      = stride_q;
        wpr_d         = wpr_q;
        row_base_d    = row_base_q;
        word_idx_d    = word_idx_q;
        req_row_d     = req_row_q;
        req_active_d  = req_active_q;
        bit_idx_d     = bit_idx_q;
        pix_col_d     = pix_col_q;
        pix_row_d     = pix_row_q;
        outstanding_d = mem_request ? 1'b1 : (mem_ack ? 1'b0 : outstanding_q);

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    width_d      = cmd_in.width;
                    height_d     = cmd_in.height;
                    stride_d     = cmd_in.stride;
                    wpr_d        = 16'((32'(cmd_in.width) + PIX_PER_WORD - 1) / PIX_PER_WORD);
                    row_base_d   = cmd_in.addr & 16'hFFFC;
                    word_idx_d   = 16'd0;
                    req_row_d    = 16'd0;
                    bit_idx_d    = 5'd0;
                    pix_col_d    = 16'd0;
                    pix_row_d    = 16'd0;
                    req_active_d = !degenerate;
                    state_d      = degenerate ? StFinish : StRun;
                end
            end
            StRun: begin
                if (mem_request) begin
                    if (last_word) begin
                        word_idx_d = 16'd0;
                        row_base_d = row_base_q + (stride_q & 16'hFFFC);
                        req_row_d  = req_row_q + 16'd1;
                        if (last_row) begin
                            req_active_d = 1'b0;
                        end
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                    end
                end
                if (pix_fire) begin
                    if (pix_eol) begin
                        bit_idx_d = 5'd0;
                        pix_col_d = 16'd0;
                        pix_row_d = pix_row_q + 16'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        pix_col_d = pix_col_q + 16'd1;
                    end
                    if (pix_eof) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            width_q       <= 16'd0;
            height_q      <= 16'd0;
            stride_q      <= 16'd0;
            wpr_q         <= 16'd0;
            row_base_q    <= 16'd0;
            word_idx_q    <= 16'd0;
            req_row_q     <= 16'd0;
            req_active_q  <= 1'b0;
            outstanding_q <= 1'b0;
            bit_idx_q     <= 5'd0;
            pix_col_q     <= 16'd0;
            pix_row_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            stride_q      <= stride_d;
            wpr_q         <= wpr_d;
            row_base_q    <= row_base_d;
            word_idx_q    <= word_idx_d;
            req_row_q     <= req_row_d;
            req_active_q  <= req_active_d;
            outstanding_q <= outstanding_d;
            bit_idx_q     <= bit_idx_d;
            pix_col_q     <= pix_col_d;
            pix_row_q     <= pix_row_d;
        end
    end

endmodule

// File: tb/tb_pattern_fetch.sv
// Self-checking bench for pattern_fetch: table of rectangle commands with
// hand-computed read counts/addresses, plus a reference pixel model, and a
// hand-written reset-during-ack sequence.
module tb_pattern_fetch;

    localparam int unsigned MAX_W_BITS = 11;
    localparam int unsigned MAX_H_BITS = 10;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [15:0]           cmd_addr;
    logic [MAX_W_BITS-1:0] cmd_width;
    logic [MAX_H_BITS-1:0] cmd_height;
    logic [15:0]           cmd_stride;
    logic                  mem_request;
    logic [15:0]           mem_addr;
    logic                  mem_write;
    logic [3:0]            mem_byte_enable;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ack;
    logic                  pix_valid;
    logic                  pix_ready = 1'b1;
    logic                  pix_data;
    logic                  pix_eol;
    logic                  pix_eof;
    logic                  busy;
    logic                  done;

    always #5 clock = ~clock;

    pattern_fetch #(
        .MAX_W_BITS(MAX_W_BITS),
        .MAX_H_BITS(MAX_H_BITS)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_width      (cmd_width),
        .cmd_height     (cmd_height),
        .cmd_stride     (cmd_stride),
        .mem_request    (mem_request),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_eol        (pix_eol),
        .pix_eof        (pix_eof),
        .busy           (busy),
        .done           (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [15:0] a);
        if (a == 16'h0100) return 32'h0000_00A5;
        return {a ^ 16'h5A3C, ~a} ^ 32'h1357_9BDF;
    endfunction

    // Memory: answers every request exactly one cycle later.
    logic        resp_ack   = 1'b0;
    logic [31:0] resp_data  = 32'h0;
    logic        stray_ack  = 1'b0;
    logic [31:0] stray_data = 32'h0;

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = stray_ack ? stray_data : resp_data;

    always @(posedge clock) begin
        resp_ack  <= mem_request;
        resp_data <= mem_request ? mem_model(mem_addr) : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Consumer ready: mode 0 always ready, mode 1 cycles 1,0,0,1.
    int ready_mode = 0;
    int rphase     = 0;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) begin
                pix_ready = 1'b1;
            end else begin
                pix_ready = (rphase == 0) || (rphase == 3);
                rphase    = (rphase + 1) % 4;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    bit          mon_en = 1'b0;
    logic [15:0] rd_q[$];
    logic [2:0]  px_q[$];
    int pix_cnt, eol_cnt, eof_cnt, done_cnt;
    int first_req_cyc, first_pix_cyc, eof_cyc, done_cyc;
    int run_len, max_run, stall_bad, buffered, max_occ, tb_bit;
    bit          prev_stall;
    logic [3:0]  prev_out;

    task automatic clear_mon();
        rd_q.delete();
        px_q.delete();
        pix_cnt = 0; eol_cnt = 0; eof_cnt = 0; done_cnt = 0;
        first_req_cyc = -1; first_pix_cyc = -1; eof_cyc = -1; done_cyc = -1;
        run_len = 0; max_run = 0; stall_bad = 0; buffered = 0; max_occ = 0; tb_bit = 0;
        prev_stall = 1'b0; prev_out = 4'h0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_request) begin
                rd_q.push_back(mem_addr);
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (pix_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (first_pix_cyc < 0) first_pix_cyc = cyc;
            end else begin
                run_len = 0;
            end
            if (prev_stall && ({pix_valid, pix_data, pix_eol, pix_eof} !== prev_out)) stall_bad++;
            prev_stall = pix_valid && !pix_ready;
            prev_out   = {pix_valid, pix_data, pix_eol, pix_eof};
            if (buffered + (mem_ack ? 1 : 0) > max_occ) max_occ = buffered + (mem_ack ? 1 : 0);
            if (pix_valid && pix_ready) begin
                px_q.push_back({pix_data, pix_eol, pix_eof});
                pix_cnt++;
                if (pix_eol) eol_cnt++;
                if (pix_eof) begin
                    eof_cnt++;
                    eof_cyc = cyc;
                end
                if (pix_eol || tb_bit == 31) begin
                    buffered--;
                    tb_bit = 0;
                end else begin
                    tb_bit++;
                end
            end
            if (mem_ack) buffered++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        int          width;
        int          height;
        logic [15:0] stride;
        int          mode;
        int          exp_reads;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_pix;
        int          exp_eol;
        int          exp_run;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int          c0, n, mism, nw;
        logic [15:0] a, st;
        logic [31:0] w;
        logic [15:0] exp_rd[$];
        logic [2:0]  exp_px[$];
        string       p;

        p  = $sformatf("v%0d", idx);
        st = v.stride & 16'hFFFC;
        nw = (v.width + 31) / 32;
        for (int r = 0; r < v.height; r++) begin
            for (int k = 0; k < nw; k++) begin
                exp_rd.push_back(16'((v.addr & 16'hFFFC) + r * st + 4 * k));
            end
            for (int c = 0; c < v.width; c++) begin
                a = 16'((v.addr & 16'hFFFC) + r * st + 4 * (c / 32));
                w = mem_model(a);
                exp_px.push_back({w[c % 32], c == v.width - 1,
                                  (c == v.width - 1) && (r == v.height - 1)});
            end
        end

        clear_mon();
        ready_mode = v.mode;
        rphase     = 0;
        mon_en     = 1'b1;
        @(negedge clock);
        cmd_addr   = v.addr;
        cmd_width  = v.width[MAX_W_BITS-1:0];
        cmd_height = v.height[MAX_H_BITS-1:0];
        cmd_stride = v.stride;
        cmd_valid  = 1'b1;
        check({p, "_cmd_ready_idle"}, cmd_ready, 1);
        c0 = cyc;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check({p, "_busy_after_accept"}, busy, 1);
        check({p, "_cmd_ready_busy"}, cmd_ready, 0);

        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clock);
            #1;
            n++;
        end
        repeat (4) @(negedge clock);
        #1;
        mon_en = 1'b0;

        check({p, "_done_pulses"}, done_cnt, 1);
        check({p, "_idle_after"}, cmd_ready, 1);
        check({p, "_reads"}, rd_q.size(), v.exp_reads);
        if (rd_q.size() > 0 && v.exp_reads > 0) begin
            check({p, "_first_addr"}, rd_q[0], v.exp_first);
            check({p, "_last_addr"}, rd_q[rd_q.size()-1], v.exp_last);
            check({p, "_req_latency"}, first_req_cyc, c0 + 1);
        end
        mism = 0;
        if (rd_q.size() != exp_rd.size()) mism++;
        else foreach (rd_q[i]) if (rd_q[i] !== exp_rd[i]) mism++;
        check({p, "_read_list"}, mism, 0);

        check({p, "_pix_count"}, pix_cnt, v.exp_pix);
        check({p, "_eol_count"}, eol_cnt, v.exp_eol);
        check({p, "_eof_count"}, eof_cnt, (v.exp_pix > 0) ? 1 : 0);
        mism = 0;
        if (px_q.size() != exp_px.size()) mism++;
        else foreach (px_q[i]) if (px_q[i] !== exp_px[i]) mism++;
        check({p, "_pix_stream"}, mism, 0);
        check({p, "_stall_stable"}, stall_bad, 0);
        check({p, "_occupancy_le3"}, (max_occ <= 3) ? 1 : 0, 1);

        if (v.exp_pix == 0) begin
            check({p, "_done_latency"}, done_cyc, c0 + 1);
            check({p, "_no_pix"}, first_pix_cyc, -1);
        end else begin
            check({p, "_pix_latency"}, first_pix_cyc, c0 + 3);
            check({p, "_done_after_eof"}, done_cyc, eof_cyc + 1);
        end
        if (v.exp_run > 0) check({p, "_consecutive_valid"}, max_run, v.exp_run);
    endtask

    task automatic reset_mid_cmd();
        int n;
        bit hit;
        int bad;
        clear_mon();
        ready_mode = 0;
        mon_en     = 1'b1;
        @(negedge clock);
        cmd_addr   = 16'h0500;
        cmd_width  = 11'd64;
        cmd_height = 10'd2;
        cmd_stride = 16'h0040;
        cmd_valid  = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 20) begin
            @(negedge clock);
            #1;
            if (mem_ack) hit = 1'b1;
            n++;
        end
        check("rst_saw_ack", hit, 1);
        resetn = 1'b0;
        #1;
        check("rst_async_cmd_ready", cmd_ready, 1);
        check("rst_async_busy", busy, 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst_rel_cmd_ready", cmd_ready, 1);
        check("rst_rel_pix_valid", pix_valid, 0);
        check("rst_rel_mem_request", mem_request, 0);
        @(negedge clock);
        #1;
        stray_data = 32'hFFFF_FFFF;
        stray_ack  = 1'b1;
        @(posedge clock);
        #1;
        stray_ack = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            #1;
            if (pix_valid || busy || mem_request) bad++;
        end
        check("stray_ack_ignored", bad, 0);
        check("rst_no_done", done_cnt, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 16'h0;
        cmd_width  = '0;
        cmd_height = '0;
        cmd_stride = 16'h0;

        //          addr      w   h  stride  mode rd  first     last      pix eol run
        vecs[0] = '{16'h0100, 8,  1, 16'h0000, 0, 1, 16'h0100, 16'h0100, 8,  1, 8};
        vecs[1] = '{16'h0200, 40, 2, 16'h0010, 0, 4, 16'h0200, 16'h0214, 80, 2, 0};
        vecs[2] = '{16'h0200, 40, 2, 16'h0010, 1, 4, 16'h0200, 16'h0214, 80, 2, 0};
        vecs[3] = '{16'h0300, 0,  5, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0,  0, 0};
        vecs[4] = '{16'hFFFC, 64, 1, 16'h0000, 0, 2, 16'hFFFC, 16'h0000, 64, 1, 64};
        vecs[5] = '{16'h0400, 96, 1, 16'h0000, 0, 3, 16'h0400, 16'h0408, 96, 1, 96};
        vecs[6] = '{16'h0203, 33, 2, 16'h0013, 1, 4, 16'h0200, 16'h0214, 66, 2, 0};

        repeat (2) @(negedge clock);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_mem_request", mem_request, 0);
        check("reset_pix_flags", {pix_data, pix_eol, pix_eof}, 3'b000);
        check("tie_mem_write", mem_write, 0);
        check("tie_byte_enable", mem_byte_enable, 4'hF);
        check("tie_wdata", mem_wdata, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        reset_mid_cmd();
        run_vec(vecs[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
